// File: rtl/ula_control_mc.sv
// ALU control unit: decodes aluop/function fields into a registered ALU control word,
// and holds that word for MUL/DIV while stalling the issuing stage for a fixed latency.
module ula_control_mc #(
  parameter int FUNCR_W = 4,
  parameter int FUNC_W  = 2,
  parameter int CTL_W   = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [1:0]         aluop,
  input  logic [FUNCR_W-1:0] func_tipor,
  input  logic [FUNC_W-1:0]  func_code,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [CTL_W-1:0]   alu_ctl,
  output logic               out_valid,
  output logic               illegal,
  output logic               busy,
  output logic               state_dbg
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // in_ready is low while iterating, while flush is high and while reset is held.

  typedef enum logic {IDLE = 1'b0, ITER = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CTL_W-1:0] ctl_n;
  logic             out_valid_n, illegal_n;

  logic [3:0] dec_code;
  logic       dec_illegal, dec_mul, dec_div;
  logic       hi_r, hi_i;
  logic       accept;

  // Function-field bits above the decoded nibble/pair make the op illegal.
  assign hi_r = |(func_tipor >> 4);
  assign hi_i = |(func_code >> 2);

  always_comb begin
    dec_code    = 4'b0010;
    dec_illegal = 1'b0;
    dec_mul     = 1'b0;
    dec_div     = 1'b0;
    case (aluop)
      2'b00: dec_code = 4'b0010;
      2'b01: dec_code = 4'b0110;
      2'b10: begin
        if (hi_r) begin
          dec_illegal = 1'b1;
        end else begin
          case (func_tipor[3:0])
            4'b0000: dec_code = 4'b0010;
            4'b0001: dec_code = 4'b0110;
            4'b0010: dec_code = 4'b0000;
            4'b0011: dec_code = 4'b0001;
            4'b0100: dec_code = 4'b0111;
            4'b0101: dec_code = 4'b1100;
            4'b0110: begin dec_code = 4'b1000; dec_mul = 1'b1; end
            4'b0111: begin dec_code = 4'b1001; dec_div = 1'b1; end
            default: dec_illegal = 1'b1;
          endcase
        end
      end
      default: begin
        if (hi_i) begin
          dec_illegal = 1'b1;
        end else begin
          case (func_code[1:0])
            2'b00:   dec_code = 4'b0010;
            2'b01:   dec_code = 4'b0000;
            2'b10:   dec_code = 4'b0001;
            default: dec_code = 4'b0111;
          endcase
        end
      end
    endcase
  end

  assign in_ready  = reset && (state == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign busy      = (state == ITER);
  assign state_dbg = state;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    ctl_n       = alu_ctl;
    out_valid_n = 1'b0;
    illegal_n   = 1'b0;
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (dec_mul || dec_div) begin
              ctl_n   = CTL_W'(dec_code);
              cnt_n   = dec_mul ? MUL_CNT : DIV_CNT;
              state_n = ITER;
            end else begin
              ctl_n       = dec_illegal ? '1 : CTL_W'(dec_code);
              out_valid_n = 1'b1;
              illegal_n   = dec_illegal;
            end
          end
        end
        ITER: begin
          // The count stops at zero; completion is signalled on the edge that sees it.
          if (cnt == '0) begin
            state_n     = IDLE;
            out_valid_n = 1'b1;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_ctl   <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      alu_ctl   <= ctl_n;
      out_valid <= out_valid_n;
      illegal   <= illegal_n;
    end
  end

endmodule

// File: tb/tb_ula_control_mc.sv
// Directed bench for ula_control_mc: expected {illegal, alu_ctl} pairs are queued when a
// request is issued and compared whenever out_valid is seen on a falling edge.
module tb_ula_control_mc;

  localparam int FUNCR_W = 6;
  localparam int FUNC_W  = 2;
  localparam int CTL_W   = 4;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;
  localparam int CNT_W   = 4;

  logic               clock;
  logic               reset;
  logic               flush;
  logic [1:0]         aluop;
  logic [FUNCR_W-1:0] func_tipor;
  logic [FUNC_W-1:0]  func_code;
  logic               in_valid;
  logic               in_ready;
  logic [CTL_W-1:0]   alu_ctl;
  logic               out_valid;
  logic               illegal;
  logic               busy;
  logic               state_dbg;

  int checks = 0;
  int errors = 0;
  logic [CTL_W:0] exp_q[$];

  ula_control_mc #(
    .FUNCR_W(FUNCR_W), .FUNC_W(FUNC_W), .CTL_W(CTL_W),
    .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush), .aluop(aluop),
    .func_tipor(func_tipor), .func_code(func_code), .in_valid(in_valid),
    .in_ready(in_ready), .alu_ctl(alu_ctl), .out_valid(out_valid),
    .illegal(illegal), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic ill, input logic [CTL_W-1:0] ctl);
    exp_q.push_back({ill, ctl});
  endtask

  // Driver tasks: inputs change on falling edges, the DUT samples on the next rising edge.
  task automatic drive(input logic v, input logic [1:0] op, input logic [FUNCR_W-1:0] fr,
                       input logic [FUNC_W-1:0] fi);
    in_valid   = v;
    aluop      = op;
    func_tipor = fr;
    func_code  = fi;
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Scoreboard
  logic [CTL_W:0] exp_item;
  always @(negedge clock) begin
    if (reset && out_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out_valid: got alu_ctl=%0h expected no output", alu_ctl);
      end
      if (exp_q.size() != 0) begin
        exp_item = exp_q.pop_front();
        check("out_alu_ctl", alu_ctl, exp_item[CTL_W-1:0]);
        check("out_illegal", illegal, exp_item[CTL_W]);
      end
    end
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, '0, '0);
    tick();
    check("rst_alu_ctl", alu_ctl, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b1;
    #1 check("post_rst_in_ready", in_ready, 1);

    // Load/store then branch
    drive(1'b1, 2'b00, '0, '0); push(1'b0, 4'b0010);
    tick();
    drive(1'b1, 2'b01, '0, '0); push(1'b0, 4'b0110);
    tick();
    // Back-to-back R-type and one I-type
    drive(1'b1, 2'b10, 6'd2, '0); push(1'b0, 4'b0000); tick();
    drive(1'b1, 2'b10, 6'd3, '0); push(1'b0, 4'b0001); tick();
    drive(1'b1, 2'b10, 6'd5, '0); push(1'b0, 4'b1100); tick();
    drive(1'b1, 2'b10, 6'd4, '0); push(1'b0, 4'b0111); tick();
    drive(1'b1, 2'b11, '0, 2'b10); push(1'b0, 4'b0001); tick();
    drive(1'b0, 2'b00, '0, '0);
    tick();
    check("idle_out_valid", out_valid, 0);
    check("idle_illegal", illegal, 0);
    check("idle_alu_ctl_hold", alu_ctl, 4'b0001);

    // MUL with a request held while busy
    drive(1'b1, 2'b10, 6'd6, '0); push(1'b0, 4'b1000);
    tick();
    drive(1'b1, 2'b10, 6'd0, '0); push(1'b0, 4'b0010);
    for (int i = 0; i < MUL_LAT; i++) begin
      check("mul_busy", busy, 1);
      check("mul_in_ready", in_ready, 0);
      check("mul_alu_ctl", alu_ctl, 4'b1000);
      if (i < MUL_LAT - 1) tick();
    end
    tick();
    check("mul_done_busy", busy, 0);
    check("mul_done_out_valid", out_valid, 1);
    tick();
    check("held_req_out_valid", out_valid, 1);
    drive(1'b0, 2'b00, '0, '0);
    tick();

    // DIV aborted by flush
    drive(1'b1, 2'b10, 6'd7, '0);
    tick();
    drive(1'b0, 2'b00, '0, '0);
    check("div_busy", busy, 1);
    tick();
    tick();
    flush = 1'b1;
    #1 check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_alu_ctl_hold", alu_ctl, 4'b1001);
    #1 check("flush_in_ready_after", in_ready, 1);
    repeat (DIV_LAT + 2) tick();
    check("flush_no_late_busy", busy, 0);

    // flush and in_valid together: no accept
    flush = 1'b1;
    drive(1'b1, 2'b00, '0, '0);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, '0, '0);
    check("flush_vs_valid_out_valid", out_valid, 0);
    check("flush_vs_valid_alu_ctl", alu_ctl, 4'b1001);

    // Illegal encodings, including upper function bits set
    drive(1'b1, 2'b10, 6'b001000, '0); push(1'b1, 4'b1111); tick();
    drive(1'b1, 2'b10, 6'b010000, '0); push(1'b1, 4'b1111); tick();
    drive(1'b0, 2'b00, '0, '0);
    tick();
    check("illegal_clears", illegal, 0);

    // Asynchronous reset in the middle of a DIV
    drive(1'b1, 2'b10, 6'd7, '0);
    tick();
    drive(1'b0, 2'b00, '0, '0);
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("async_rst_alu_ctl", alu_ctl, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_state", state_dbg, 0);
    tick();
    tick();
    reset = 1'b1;
    #1 check("rerelease_in_ready", in_ready, 1);
    drive(1'b1, 2'b00, '0, '0); push(1'b0, 4'b0010);
    tick();
    drive(1'b0, 2'b00, '0, '0);
    tick();
    tick();
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
